// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state encodings for the PISO serializer and matching SIPO receiver
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_bit_cnt.sv
// rtl/piso_bit_cnt.sv - frame bit counter with clear/enable and last-count flag
module piso_bit_cnt #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       en,
    output logic [$clog2(WIDTH)-1:0]   count,
    output logic                       last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    assign last = (count == LAST_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with framing strobes
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    piso_state_e         state, state_n;
    logic [WIDTH-1:0]    sreg;
    logic [CW-1:0]       bit_count;
    logic                bit_last;
    logic                accept;
    logic                data_bit;

    assign accept = load_valid && load_ready;

    piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (state == ST_SHIFT),
        .count (bit_count),
        .last  (bit_last)
    );

    assign data_bit = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

`ifdef PISO_PARITY_EN
    logic parity_q;

    // Parity is computed from the captured word so the trailer needs no accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^parallel_in;
        end
    end

    assign frame_done = (state == ST_PARITY);
    assign serial_out = (state == ST_SHIFT)  ? data_bit :
                        (state == ST_PARITY) ? parity_q : 1'b0;
`else
    assign frame_done = (state == ST_SHIFT) && bit_last;
    assign serial_out = (state == ST_SHIFT) ? data_bit : 1'b0;
`endif

    assign serial_valid = (state != ST_IDLE);
    assign busy         = serial_valid;
    assign frame_start  = (state == ST_SHIFT) && (bit_count == '0);
    assign load_ready   = (state == ST_IDLE) || frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_last) begin
`ifdef PISO_PARITY_EN
                    state_n = ST_PARITY;
`else
                    state_n = accept ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
            ST_PARITY: begin
                state_n = accept ? ST_SHIFT : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (accept) begin
            sreg <= parallel_in;
        end else if (state == ST_SHIFT) begin
            sreg <= (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (MSB-first and LSB-first instances)
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
    localparam bit PAR = 1'b1;
`else
    localparam int FL = 8;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] parallel_in = 8'h00;
    logic       load_valid = 1'b0;
    logic       sel = 1'b0;

    logic lr_a, so_a, sv_a, fs_a, fd_a, bz_a;
    logic lr_b, so_b, sv_b, fs_b, fd_b, bz_b;
    logic lr, so, sv, fs, fd, bz;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .parallel_in(parallel_in),
        .load_valid(load_valid && !sel), .load_ready(lr_a),
        .serial_out(so_a), .serial_valid(sv_a), .frame_start(fs_a),
        .frame_done(fd_a), .busy(bz_a)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .parallel_in(parallel_in),
        .load_valid(load_valid && sel), .load_ready(lr_b),
        .serial_out(so_b), .serial_valid(sv_b), .frame_start(fs_b),
        .frame_done(fd_b), .busy(bz_b)
    );

    assign lr = sel ? lr_b : lr_a;
    assign so = sel ? so_b : so_a;
    assign sv = sel ? sv_b : sv_a;
    assign fs = sel ? fs_b : fs_a;
    assign fd = sel ? fd_b : fd_a;
    assign bz = sel ? bz_b : bz_a;

    // Reference: frame position i of word w, independent of any shifting.
    function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
        if (i >= 8) return ^w;
        return msb ? w[7 - i] : w[i];
    endfunction

    task automatic check_idle(input string name);
        total++;
        if ({lr, sv, so, fs, fd, bz} !== 6'b100000) begin
            bad++;
            $display("FAIL %s: ready/valid/out/start/done/busy=%b required 100000", name,
                     {lr, sv, so, fs, fd, bz});
        end
    endtask

    // Caller has load_valid=1 with w on parallel_in at a negedge; the next posedge accepts.
    task automatic send_check(input logic [7:0] w, input int drop_at, input int abort_at,
                              input bit chain, input logic [7:0] w2);
        logic [4:0] got, want;
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            got  = {sv, so, fs, fd, lr};
            want = {1'b1, exp_bit(w, i, !sel), (i == 0), (i == FL - 1), (i == FL - 1)};
            total++;
            if (got !== want || bz !== 1'b1) begin
                bad++;
                $display("FAIL frame w=%h bit%0d: valid/out/start/done/ready=%b busy=%b required %b busy=1",
                         w, i, got, bz, want);
            end
            load_valid = 1'b0;
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_idle("abort_async");
                return;
            end
            if (i == drop_at) begin
                load_valid  = 1'b1;
                parallel_in = 8'hFF;
            end
            if (i == FL - 1 && chain) begin
                load_valid  = 1'b1;
                parallel_in = w2;
            end
        end
        if (!chain) begin
            @(negedge clk);
            check_idle("post_frame_idle");
        end
    endtask

    task automatic start(input logic [7:0] w);
        @(negedge clk);
        load_valid  = 1'b1;
        parallel_in = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_valid = 1'b1;
        parallel_in = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset_hold");
        end
        load_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_idle("after_reset");
        end
    endtask

    task automatic test_single();
        start(8'hA5);
        send_check(8'hA5, -1, -1, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        start(8'hA5);
        send_check(8'hA5, -1, -1, 1'b1, 8'h3C);
        send_check(8'h3C, -1, -1, 1'b0, 8'h00);
    endtask

    task automatic test_busy_drop();
        start(8'h00);
        send_check(8'h00, 2, -1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("no_ff_frame");
        end
    endtask

    task automatic test_abort();
        start(8'hA5);
        send_check(8'hA5, -1, 3, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_idle("abort_hold");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("abort_release");
        start(8'h5A);
        send_check(8'h5A, -1, -1, 1'b0, 8'h00);
    endtask

    task automatic test_lsb_first();
        sel = 1'b1;
        @(negedge clk);
        check_idle("lsb_idle");
        start(8'h07);
        send_check(8'h07, -1, -1, 1'b0, 8'h00);
        total++;
        if (exp_bit(8'h07, 8, 1'b0) !== 1'b1 && PAR) begin
            bad++;
            $display("FAIL parity_model: got %b required 1", exp_bit(8'h07, 8, 1'b0));
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] w, nxt;
        bit chain;
        for (int n = 0; n < 2; n++) begin
            sel = n[0];
            w = 8'($urandom);
            start(w);
            for (int k = 0; k < 12; k++) begin
                nxt   = 8'($urandom);
                chain = ($urandom_range(0, 1) == 1) && (k != 11);
                send_check(w, (chain ? -1 : int'($urandom_range(0, FL - 2))), -1, chain, nxt);
                if (!chain && k != 11) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    start(nxt);
                end
                w = nxt;
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_drop();
        test_abort();
        test_lsb_first();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
